// File: rtl/crypt_pkg.sv
// Shared alphabet constants, one-hot type and character helpers for the shift decryptor.
// Pure definitions: no latency, no flow control.
package crypt_pkg;
    localparam int ALPHA_LEN     = 26;
    localparam int ASCII_UPPER_A = 65;
    localparam int ASCII_LOWER_A = 97;
    localparam int KEY_W         = 5;

    typedef logic [ALPHA_LEN-1:0] onehot26_t;

    typedef enum logic [1:0] {
        CLS_OTHER,
        CLS_UPPER,
        CLS_LOWER
    } char_cls_t;

    function automatic char_cls_t classify(input logic [7:0] c);
        char_cls_t cls;
        cls = CLS_OTHER;
        if (c >= 8'(ASCII_UPPER_A) && c < 8'(ASCII_UPPER_A + ALPHA_LEN))
            cls = CLS_UPPER;
        else if (c >= 8'(ASCII_LOWER_A) && c < 8'(ASCII_LOWER_A + ALPHA_LEN))
            cls = CLS_LOWER;
        return cls;
    endfunction

    // Non-alphabetic bytes decode to all-zero; their raw byte is carried separately.
    function automatic onehot26_t to_onehot(input logic [7:0] c, input char_cls_t cls);
        onehot26_t  oh;
        logic [7:0] idx;
        oh  = '0;
        idx = c - ((cls == CLS_UPPER) ? 8'(ASCII_UPPER_A) : 8'(ASCII_LOWER_A));
        if (cls != CLS_OTHER)
            oh = onehot26_t'(1) << idx;
        return oh;
    endfunction

    function automatic logic [KEY_W-1:0] onehot_idx(input onehot26_t oh);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ALPHA_LEN; i++)
            if (oh[i])
                idx = idx | KEY_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/decrypt_rot26.sv
// Rotates a 26-bit one-hot letter index right by key (index - key mod 26).
// Combinational, zero latency, no flow control.
module decrypt_rot26
    import crypt_pkg::*;
(
    input  onehot26_t        oh_in,
    input  logic [KEY_W-1:0] key,
    output onehot26_t        oh_out
);

    always_comb begin
        oh_out = '0;
        for (int i = 0; i < ALPHA_LEN; i++)
            oh_out[i] = oh_in[(i + int'(key)) % ALPHA_LEN];
    end

endmodule

// File: rtl/decrypt_pipe_shift.sv
// Caesar-shift decryptor: S1 classify/one-hot, S2 rotate by key, S3 re-encode ASCII.
// Latency 3 cycles en->en_out; accepts one byte every cycle, no backpressure.
module decrypt_pipe_shift
    import crypt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       din,
    input  logic             shift_en,
    input  logic             mode,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             cnt_clr,
    output logic             en_out,
    output logic [7:0]       dout,
    output logic             key_err,
    output logic [CNT_W-1:0] alpha_cnt
);

    logic [KEY_W-1:0] key;
    char_cls_t        din_cls;

    logic             s1_vld, s1_shift, s1_upper;
    logic [7:0]       s1_raw;
    onehot26_t        s1_oh;
    logic [KEY_W-1:0] s1_key;

    logic             s2_vld, s2_shift, s2_upper;
    logic [7:0]       s2_raw;
    onehot26_t        s2_oh;

    onehot26_t        rot_oh;
    logic [7:0]       s2_chr;
    logic             out_shift;

    assign din_cls = classify(din);

    // A rejected key leaves the old key in place and flags the next cycle only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key     <= '0;
            key_err <= 1'b0;
        end else begin
            key_err <= key_load && (key_in >= KEY_W'(ALPHA_LEN));
            if (key_load && (key_in < KEY_W'(ALPHA_LEN)))
                key <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld   <= 1'b0;
            s1_shift <= 1'b0;
            s1_upper <= 1'b0;
            s1_raw   <= '0;
            s1_oh    <= '0;
            s1_key   <= '0;
        end else begin
            s1_vld   <= en;
            s1_shift <= en && mode && shift_en && (din_cls != CLS_OTHER);
            s1_upper <= (din_cls == CLS_UPPER);
            s1_raw   <= din;
            s1_oh    <= to_onehot(din, din_cls);
            s1_key   <= key;
        end
    end

    decrypt_rot26 u_rot (
        .oh_in  (s1_oh),
        .key    (s1_key),
        .oh_out (rot_oh)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_vld   <= 1'b0;
            s2_shift <= 1'b0;
            s2_upper <= 1'b0;
            s2_raw   <= '0;
            s2_oh    <= '0;
        end else begin
            s2_vld   <= s1_vld;
            s2_shift <= s1_shift;
            s2_upper <= s1_upper;
            s2_raw   <= s1_raw;
            s2_oh    <= rot_oh;
        end
    end

    assign s2_chr = (s2_upper ? 8'(ASCII_UPPER_A) : 8'(ASCII_LOWER_A))
                  + {3'b000, onehot_idx(s2_oh)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_out    <= 1'b0;
            out_shift <= 1'b0;
            dout      <= '0;
        end else begin
            en_out    <= s2_vld;
            out_shift <= s2_vld && s2_shift;
            dout      <= !s2_vld ? 8'h00 : (s2_shift ? s2_chr : s2_raw);
        end
    end

    // Counts a delivered shifted byte on the edge closing its en_out cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            alpha_cnt <= '0;
        else if (cnt_clr)
            alpha_cnt <= '0;
        else if (en_out && out_shift && (alpha_cnt != {CNT_W{1'b1}}))
            alpha_cnt <= alpha_cnt + CNT_W'(1);
    end

endmodule

// File: doc/decrypt_pipe_shift.md
DECRYPT_PIPE_SHIFT -- requirements
Module: decrypt_pipe_shift

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the alpha character counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en  input  1  input byte valid.
REQ-005 SHALL have port din  input  8  ciphertext ASCII byte.
REQ-006 SHALL have port shift_en  input  1  1 = apply shift to alphabetic bytes; 0 = pass byte unchanged.
REQ-007 SHALL have port mode  input  1  1 = decrypt active; 0 = bypass, dout = din.
REQ-008 SHALL have port key_load  input  1  load request for the shift key.
REQ-009 SHALL have port key_in  input  5  new shift key, legal range 0..25.
REQ-010 SHALL have port cnt_clr  input  1  clears alpha_cnt.
REQ-011 SHALL have port en_out  output  1  output byte valid.
REQ-012 SHALL have port dout  output  8  plaintext ASCII byte.
REQ-013 SHALL have port key_err  output  1  one-cycle pulse on rejected key load.
REQ-014 SHALL have port alpha_cnt  output  CNT_W  count of shifted alphabetic bytes delivered.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 classify (upper/lower/other) and one-hot decode to 26 bits; S2 rotate one-hot right by key; S3 re-encode to ASCII with case restored.
REQ-016 SHALL deliver a byte with en=1 at edge N as en_out=1 with dout valid after edge N+3; en_out SHALL be a 3-cycle delayed copy of en.
REQ-017 SHALL accept one byte per cycle with no backpressure and no bubbles.
REQ-018 SHALL compute, for alphabetic din with mode=1 and shift_en=1, plaintext index = (cipher index - key) mod 26, case preserved ('A'..'Z' = 65..90, 'a'..'z' = 97..122).
REQ-019 SHALL output dout = din unchanged for non-alphabetic din, shift_en=0, or mode=0.
REQ-020 SHALL drive dout = 0 whenever en_out = 0.
REQ-021 SHALL sample key, mode and shift_en into S1 alongside din, so each byte uses the values present on its own input cycle.
REQ-022 SHALL update the key register on the edge where key_load=1 and key_in <= 25; a byte with en=1 on that same edge SHALL use the old key.
REQ-023 SHALL, when key_load=1 and key_in > 25, leave the key unchanged and assert key_err for exactly the following cycle.
REQ-024 SHALL increment alpha_cnt by 1 on each cycle where en_out=1 and the delivered byte was shifted (alphabetic, mode=1, shift_en=1).
REQ-025 SHALL saturate alpha_cnt at all-ones.
REQ-026 SHALL clear alpha_cnt on cnt_clr=1; clear SHALL win over a simultaneous increment.
REQ-027 SHALL treat key=0 as identity (dout = din).

Reset
REQ-028 SHALL, on rst=0 sampled at a rising edge, set en_out=0, dout=0, key_err=0, alpha_cnt=0, key=0 and clear all pipeline valid/data registers.
REQ-029 SHALL discard bytes in flight on reset mid-stream; en_out SHALL be 0 from the first edge with rst=0 until 3 edges after the first valid input following release.

Structure
REQ-030 SHALL place ALPHA_LEN=26, ASCII_UPPER_A=65, ASCII_LOWER_A=97, KEY_W=5 and typedef onehot26_t (26-bit) in shared package crypt_pkg.
REQ-031 SHALL implement the S2 rotate as combinational sub-module decrypt_rot26 (inputs onehot26_t and key, output onehot26_t).

Verification
REQ-032 SHALL test: load key_in=3, then din='D' (68) -> dout='A' (65), en_out=1 three cycles later, alpha_cnt=1.
REQ-033 SHALL test wrap: key=1, din='a' (97) -> dout='z' (122); key=25, din='Z' (90) -> dout='[' not produced, dout='A' (65).
REQ-034 SHALL test pass-through: din='!' (33), key=5 -> dout=33, alpha_cnt unchanged; mode=0, din='H' -> dout='H'.
REQ-035 SHALL test key_in=30 with key=4 -> key_err high one cycle, next 'E' (69) -> 'A' (65).
REQ-036 SHALL test back-to-back stream "Khoor" with key=3 -> "Hello" on 5 consecutive en_out cycles, then rst=0 mid-stream -> en_out=0, alpha_cnt=0.
REQ-037 SHALL test saturation with CNT_W=4: 20 alphabetic bytes -> alpha_cnt=15; cnt_clr with simultaneous increment -> alpha_cnt=0.
